// File: rtl/vdc_ram_sched.sv
`timescale 1ns/1ps
// vdc_ram_sched: slot-based RAM scheduler sharing one RAM port between display fetch,
// refresh, CPU and block engine. Define VDC_REFRESH_EN to build the refresh phase.
module vdc_ram_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        slot,
    input  logic        fetchLine,
    input  logic [7:0]  reg_hd,
    input  logic [3:0]  reg_drr,
    input  logic [15:0] disp_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        blk_req,
    input  logic        blk_we,
    input  logic [15:0] blk_addr,
    input  logic [7:0]  blk_din,
    input  logic [7:0]  ram_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        disp_ack,
    output logic        cpu_ack,
    output logic        blk_ack,
    output logic [7:0]  rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_REFRESH} state_t;
    typedef enum logic [1:0] {OWN_DISP, OWN_CPU, OWN_BLK, OWN_REF} owner_t;

    state_t      r_state;
    owner_t      r_owner;
    logic [8:0]  r_scnt;
    logic        r_cpu_last;
    logic        r_ram_en;
    logic        r_ram_we;
    logic [15:0] r_ram_addr;
    logic [7:0]  r_ram_wdata;
    logic        r_disp_ack;
    logic        r_cpu_ack;
    logic        r_blk_ack;
    logic [7:0]  r_rdata;

    logic [8:0]  w_disp_last;
    logic        w_cpu_ok;
    logic        w_blk_ok;
    logic        w_pick_blk;
    state_t      w_after_fetch;

    assign w_disp_last = {reg_hd, 1'b0} - 9'd1;

    // A requester whose cycle is on the RAM bus right now is not yet acked and must wait.
    assign w_cpu_ok   = cpu_req && !(r_ram_en && (r_owner == OWN_CPU));
    assign w_blk_ok   = blk_req && !(r_ram_en && (r_owner == OWN_BLK));
    assign w_pick_blk = w_blk_ok && (!w_cpu_ok || r_cpu_last);

`ifdef VDC_REFRESH_EN
    logic [7:0] r_rcnt;
    logic [8:0] w_refresh_last;
    assign w_refresh_last = {5'd0, reg_drr} - 9'd1;
    assign w_after_fetch  = (reg_drr == 4'd0) ? ST_IDLE : ST_REFRESH;
`else
    logic w_unused;
    assign w_unused      = ^reg_drr;
    assign w_after_fetch = ST_IDLE;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_DISP;
            r_scnt      <= '0;
            r_cpu_last  <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_disp_ack  <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_blk_ack   <= 1'b0;
            r_rdata     <= '0;
`ifdef VDC_REFRESH_EN
            r_rcnt      <= '0;
`endif
        end else if (enable) begin
            r_disp_ack <= r_ram_en && (r_owner == OWN_DISP);
            r_cpu_ack  <= r_ram_en && (r_owner == OWN_CPU);
            r_blk_ack  <= r_ram_en && (r_owner == OWN_BLK);
            if (r_ram_en && (r_owner != OWN_REF)) begin
                r_rdata <= ram_rdata;
            end
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;

            // Line start wins over a coincident slot; that slot goes unused.
            if (fetchLine) begin
                r_state <= ST_FETCH;
                r_scnt  <= '0;
            end else if (slot) begin
                case (r_state)
                    ST_FETCH: begin
                        if (reg_hd == 8'd0) begin
                            r_state <= w_after_fetch;
                            r_scnt  <= '0;
                        end else begin
                            r_ram_en   <= 1'b1;
                            r_owner    <= OWN_DISP;
                            r_ram_addr <= disp_addr;
                            if (r_scnt >= w_disp_last) begin
                                r_state <= w_after_fetch;
                                r_scnt  <= '0;
                            end else begin
                                r_scnt <= r_scnt + 9'd1;
                            end
                        end
                    end
`ifdef VDC_REFRESH_EN
                    ST_REFRESH: begin
                        if (reg_drr == 4'd0) begin
                            r_state <= ST_IDLE;
                            r_scnt  <= '0;
                        end else begin
                            r_ram_en   <= 1'b1;
                            r_owner    <= OWN_REF;
                            r_ram_addr <= {8'hFF, r_rcnt};
                            r_rcnt     <= r_rcnt + 8'd1;
                            if (r_scnt >= w_refresh_last) begin
                                r_state <= ST_IDLE;
                                r_scnt  <= '0;
                            end else begin
                                r_scnt <= r_scnt + 9'd1;
                            end
                        end
                    end
`endif
                    ST_IDLE: begin
                        if (w_pick_blk) begin
                            r_ram_en    <= 1'b1;
                            r_ram_we    <= blk_we;
                            r_owner     <= OWN_BLK;
                            r_ram_addr  <= blk_addr;
                            r_ram_wdata <= blk_din;
                            r_cpu_last  <= 1'b0;
                        end else if (w_cpu_ok) begin
                            r_ram_en    <= 1'b1;
                            r_ram_we    <= cpu_we;
                            r_owner     <= OWN_CPU;
                            r_ram_addr  <= cpu_addr;
                            r_ram_wdata <= cpu_din;
                            r_cpu_last  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_scnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign disp_ack  = r_disp_ack;
    assign cpu_ack   = r_cpu_ack;
    assign blk_ack   = r_blk_ack;
    assign rdata     = r_rdata;

endmodule

// File: tb/tb_vdc_ram_sched.sv
`timescale 1ns/1ps
// Bench for vdc_ram_sched: directed scenarios plus randomized traffic against a
// line-queue reference model.
module tb_vdc_ram_sched;

`ifdef VDC_REFRESH_EN
    localparam int REFRESH = 1;
`else
    localparam int REFRESH = 0;
`endif
    localparam logic [1:0] OWN_D = 2'd0, OWN_C = 2'd1, OWN_B = 2'd2, OWN_R = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, enable = 1'b1, slot = 1'b0, fetchLine = 1'b0;
    logic [7:0]  reg_hd = 8'd2;
    logic [3:0]  reg_drr = 4'd1;
    logic [15:0] disp_addr = 16'h0000;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, blk_req = 1'b0, blk_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000, blk_addr = 16'h0000;
    logic [7:0]  cpu_din = 8'h00, blk_din = 8'h00;
    logic [7:0]  ram_rdata;
    logic        ram_en, ram_we, disp_ack, cpu_ack, blk_ack;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata, rdata;

    // RAM stand-in: read data is a fixed function of the presented address.
    function automatic logic [7:0] hash(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    assign ram_rdata = hash(ram_addr);

    vdc_ram_sched dut (
        .clk(clk), .reset(reset), .enable(enable), .slot(slot), .fetchLine(fetchLine),
        .reg_hd(reg_hd), .reg_drr(reg_drr), .disp_addr(disp_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .blk_req(blk_req), .blk_we(blk_we), .blk_addr(blk_addr), .blk_din(blk_din),
        .ram_rdata(ram_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .disp_ack(disp_ack), .cpu_ack(cpu_ack), .blk_ack(blk_ack),
        .rdata(rdata)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: a line is a queue of owners to serve one per slot; outside a line, arbitration.
    logic        m_en = 0, m_we = 0, m_dack = 0, m_cack = 0, m_back = 0, m_cpu_last = 0;
    logic [15:0] m_addr = 0;
    logic [7:0]  m_wdata = 0, m_rdata = 0, m_rcnt = 0;
    logic [1:0]  m_owner = OWN_D;
    logic [1:0]  m_line[$];

    task automatic model_step();
        logic old_en, cok, bok;
        logic [1:0] old_owner, o;
        if (reset) begin
            m_en = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_dack = 0; m_cack = 0; m_back = 0;
            m_rdata = 0; m_rcnt = 0; m_cpu_last = 0; m_owner = OWN_D;
            m_line.delete();
        end else if (enable) begin
            old_en = m_en;
            old_owner = m_owner;
            m_dack = old_en && old_owner == OWN_D;
            m_cack = old_en && old_owner == OWN_C;
            m_back = old_en && old_owner == OWN_B;
            if (old_en && old_owner != OWN_R) m_rdata = hash(m_addr);
            m_en = 0;
            m_we = 0;
            if (fetchLine) begin
                m_line.delete();
                for (int i = 0; i < 2 * int'(reg_hd); i++) m_line.push_back(OWN_D);
                for (int i = 0; i < REFRESH * int'(reg_drr); i++) m_line.push_back(OWN_R);
            end else if (slot) begin
                if (m_line.size() > 0) begin
                    o = m_line.pop_front();
                    m_en = 1;
                    m_owner = o;
                    if (o == OWN_D) m_addr = disp_addr;
                    else begin
                        m_addr = {8'hFF, m_rcnt};
                        m_rcnt = m_rcnt + 8'd1;
                    end
                end else begin
                    cok = cpu_req && !(old_en && old_owner == OWN_C);
                    bok = blk_req && !(old_en && old_owner == OWN_B);
                    if (bok && (!cok || m_cpu_last)) begin
                        m_en = 1; m_owner = OWN_B; m_we = blk_we; m_addr = blk_addr;
                        m_wdata = blk_din; m_cpu_last = 0;
                    end else if (cok) begin
                        m_en = 1; m_owner = OWN_C; m_we = cpu_we; m_addr = cpu_addr;
                        m_wdata = cpu_din; m_cpu_last = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [36:0] obs_vec();
        return {ram_en, ram_we, ram_addr, ram_wdata, disp_ack, cpu_ack, blk_ack, rdata};
    endfunction
    function automatic logic [36:0] exp_vec();
        return {m_en, m_we, m_addr, m_wdata, m_dack, m_cack, m_back, m_rdata};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1;
        cyc();
        cyc();
        checks++;
        if (obs_vec() !== 37'd0) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", obs_vec(), 37'd0);
        end
        reset = 0;
        cyc();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_cpu_write();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h1234; cpu_din = 8'hA5; slot = 1;
        cyc();
        slot = 0;
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 16'h1234, 8'hA5}) begin
            failures++;
            $display("FAIL cpu_write_bus got=%h want=%h", {ram_en, ram_we, ram_addr, ram_wdata},
                     {1'b1, 1'b1, 16'h1234, 8'hA5});
        end
        cyc();
        checks++;
        if ({cpu_ack, disp_ack, blk_ack} !== 3'b100 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL cpu_write_ack got=%h want=%h", obs_vec(), exp_vec());
        end
        $display("txn cpu write addr=%h data=%h ack=%b", 16'h1234, 8'hA5, cpu_ack);
        cpu_req = 0;
        cyc();
        checks++;
        if (cpu_ack !== 1'b0) begin
            failures++;
            $display("FAIL cpu_ack_width got=%b want=0", cpu_ack);
        end
    endtask

    task automatic test_alternation();
        logic [15:0] want;
        reset = 1;
        cyc();
        reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1000;
        blk_req = 1; blk_we = 1; blk_addr = 16'h2000; blk_din = 8'h3C;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) begin
                slot = (c == 0);
                cyc();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL alt_model k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
                end
                if (c == 0) begin
                    want = (k % 2 == 0) ? 16'h1000 : 16'h2000;
                    checks++;
                    if (ram_en !== 1'b1 || ram_addr !== want) begin
                        failures++;
                        $display("FAIL alt_grant k=%0d got_en=%b got_addr=%h want_addr=%h",
                                 k, ram_en, ram_addr, want);
                    end
                    $display("txn alternation grant %0d addr=%h", k, ram_addr);
                end
            end
        end
        slot = 0; cpu_req = 0; blk_req = 0;
        cyc();
    endtask

    // One visible line with slots every gap cycles; CPU asks during FETCH and must wait for line end.
    task automatic test_line(input int hd, input int drr, input int gap);
        int dcount = 0, rcount = 0, cpu_slot = -1, total;
        logic [7:0] rexp;
        reg_hd = 8'(hd); reg_drr = 4'(drr);
        rexp = m_rcnt;
        fetchLine = 1;
        cyc();
        fetchLine = 0;
        total = 2 * hd + REFRESH * drr + 3;
        for (int s = 0; s < total; s++) begin
            if (s == 1) begin
                cpu_req = 1; cpu_we = 0; cpu_addr = 16'h8321;
            end
            for (int c = 0; c < gap; c++) begin
                slot = (c == 0);
                disp_addr = {1'b0, 15'($urandom)};
                cyc();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL line_model hd=%0d s=%0d got=%h want=%h", hd, s, obs_vec(), exp_vec());
                end
                if (c == 0 && ram_en && ram_addr == 16'h8321) cpu_slot = s;
                if (c == 0 && ram_en && ram_addr[15:8] == 8'hFF) begin
                    checks++;
                    if (ram_addr !== {8'hFF, rexp}) begin
                        failures++;
                        $display("FAIL refresh_addr got=%h want=%h", ram_addr, {8'hFF, rexp});
                    end
                    rexp = rexp + 8'd1;
                    rcount++;
                end
                if (disp_ack) dcount++;
                if (cpu_ack && cpu_req) begin
                    $display("txn cpu read addr=%h data=%h", cpu_addr, rdata);
                    cpu_req = 0;
                end
            end
        end
        slot = 0;
        repeat (3) begin
            cyc();
            if (disp_ack) dcount++;
            if (cpu_ack && cpu_req) cpu_req = 0;
        end
        $display("txn line hd=%0d drr=%0d disp_acks=%0d refreshes=%0d cpu_slot=%0d",
                 hd, drr, dcount, rcount, cpu_slot);
        checks++;
        if (dcount !== 2 * hd) begin
            failures++;
            $display("FAIL disp_count got=%0d want=%0d", dcount, 2 * hd);
        end
        checks++;
        if (rcount !== REFRESH * drr) begin
            failures++;
            $display("FAIL refresh_count got=%0d want=%0d", rcount, REFRESH * drr);
        end
        checks++;
        if (cpu_slot !== 2 * hd + REFRESH * drr) begin
            failures++;
            $display("FAIL cpu_after_line got=%0d want=%0d", cpu_slot, 2 * hd + REFRESH * drr);
        end
    endtask

`ifdef VDC_REFRESH_EN
    task automatic test_refresh_wrap();
        logic [15:0] prev = 16'h0000;
        logic [15:0] d;
        logic saw_wrap = 0;
        reg_hd = 8'd1; reg_drr = 4'd15;
        for (int line = 0; line < 19; line++) begin
            fetchLine = 1; slot = 1;
            cyc();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL wrap_fetch line=%0d got=%h want=%h", line, obs_vec(), exp_vec());
            end
            fetchLine = 0;
            for (int s = 0; s < ((line == 18) ? 5 : 17); s++) begin
                cyc();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL wrap_model line=%0d s=%0d got=%h want=%h", line, s, obs_vec(), exp_vec());
                end
                if (ram_en && ram_addr[15:8] == 8'hFF) begin
                    if (prev == 16'hFFFF && ram_addr == 16'hFF00) saw_wrap = 1;
                    prev = ram_addr;
                end
            end
        end
        checks++;
        if (saw_wrap !== 1'b1) begin
            failures++;
            $display("FAIL refresh_wrap got=%b want=1", saw_wrap);
        end
        // Mid-REFRESH line start: coincident slot unused, then display restarts from scnt 0.
        fetchLine = 1;
        cyc();
        fetchLine = 0;
        checks++;
        if (ram_en !== 1'b0) begin
            failures++;
            $display("FAIL restart_unused got=%b want=0", ram_en);
        end
        for (int s = 0; s < 3; s++) begin
            d = {1'b0, 15'($urandom)};
            disp_addr = d;
            cyc();
            checks++;
            if (ram_en !== 1'b1 || (s < 2 && ram_addr !== d) || (s == 2 && ram_addr[15:8] !== 8'hFF)) begin
                failures++;
                $display("FAIL restart_seq s=%0d got_en=%b got_addr=%h disp=%h", s, ram_en, ram_addr, d);
            end
        end
        slot = 0;
        repeat (6) cyc();
        $display("txn refresh wrap seen=%b", saw_wrap);
    endtask
`endif

    task automatic test_reset_mid();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0BEE; slot = 1;
        cyc();
        slot = 0; reset = 1;
        cyc();
        reset = 0; cpu_req = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++;
            if (cpu_ack !== 1'b0 || ram_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_drop c=%0d got_ack=%b got_en=%b want=0", c, cpu_ack, ram_en);
            end
        end
    endtask

    task automatic test_random();
        int nc = 0, nb = 0;
        reg_hd = 8'($urandom_range(1, 4));
        reg_drr = 4'($urandom_range(0, 3));
        for (int t = 0; t < 3000; t++) begin
            enable = ($urandom % 4) != 0;
            slot = ($urandom % 3) == 0;
            fetchLine = ($urandom % 60) == 0;
            reset = ($urandom % 700) == 0;
            disp_addr = 16'($urandom);
            if (cpu_ack && cpu_req) begin
                $display("txn rnd cpu we=%b addr=%h rdata=%h", cpu_we, cpu_addr, rdata);
                cpu_req = 0; nc++;
            end else if (!cpu_req && ($urandom % 4) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_din = 8'($urandom);
            end
            if (blk_ack && blk_req) begin
                $display("txn rnd blk we=%b addr=%h rdata=%h", blk_we, blk_addr, rdata);
                blk_req = 0; nb++;
            end else if (!blk_req && ($urandom % 4) == 0) begin
                blk_req = 1; blk_we = 1'($urandom); blk_addr = 16'($urandom); blk_din = 8'($urandom);
            end
            cyc();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random t=%0d got=%h want=%h", t, obs_vec(), exp_vec());
            end
        end
        enable = 1; slot = 0; fetchLine = 0; reset = 0; cpu_req = 0; blk_req = 0;
        cyc();
        $display("txn random done cpu_acks=%0d blk_acks=%0d", nc, nb);
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_alternation();
        test_line(80, 5, 1);
        test_line(2, 1, 3);
        test_line(3, 0, 2);
`ifdef VDC_REFRESH_EN
        test_refresh_wrap();
`endif
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
